// File: rtl/sb_ram_param.sv
// sb_ram_param: parametrised word SRAM slave on the simple bus.
// Independent read and write channels, each with a one-entry response slot
// so that a request is accepted every cycle as long as the master drains
// the responses. Byte strobes on writes, error responses for addresses
// outside the window, and a selectable read/write collision behaviour.
module sb_ram_param #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                COLL_MODE = 0
) (
  input  logic                sb_clk,
  input  logic                sb_rst,
  input  logic                sb_arvalid,
  output logic                sb_arready,
  input  logic [ADDR_W-1:0]   sb_araddr,
  output logic                sb_rvalid,
  input  logic                sb_rready,
  output logic [DATA_W-1:0]   sb_rdata,
  output logic                sb_rresp,
  input  logic                sb_wvalid,
  output logic                sb_wready,
  input  logic [ADDR_W-1:0]   sb_waddr,
  input  logic [DATA_W-1:0]   sb_wdata,
  input  logic [DATA_W/8-1:0] sb_wstrb,
  output logic                sb_bvalid,
  input  logic                sb_bready,
  output logic                sb_bresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rresp;
  logic              r_bvalid;
  logic              r_bresp;

  logic [ADDR_W-1:0] w_rOffset;
  logic [ADDR_W-1:0] w_rWord;
  logic [IDX_W-1:0]  w_rIdx;
  logic              w_rInRange;
  logic [ADDR_W-1:0] w_wOffset;
  logic [ADDR_W-1:0] w_wWord;
  logic [IDX_W-1:0]  w_wIdx;
  logic              w_wInRange;

  logic              w_rFire;
  logic              w_wFire;
  logic              w_collide;
  logic [DATA_W-1:0] w_wMask;
  logic [DATA_W-1:0] w_rOld;
  logic [DATA_W-1:0] w_rMerged;
  logic [DATA_W-1:0] w_rNext;

  // The word index is the offset from the window base with the byte-lane
  // bits dropped; an address below the base wraps to a huge offset, so the
  // explicit lower-bound test is what rejects it.
  assign w_rOffset  = sb_araddr - BASE_ADDR;
  assign w_rWord    = w_rOffset >> OFF_W;
  assign w_rInRange = (sb_araddr >= BASE_ADDR) && (w_rWord < ADDR_W'(DEPTH));
  assign w_rIdx     = w_rWord[IDX_W-1:0];

  assign w_wOffset  = sb_waddr - BASE_ADDR;
  assign w_wWord    = w_wOffset >> OFF_W;
  assign w_wInRange = (sb_waddr >= BASE_ADDR) && (w_wWord < ADDR_W'(DEPTH));
  assign w_wIdx     = w_wWord[IDX_W-1:0];

  // A request is taken whenever the response slot is empty or being drained.
  assign sb_arready = !r_rvalid || sb_rready;
  assign sb_wready  = !r_bvalid || sb_bready;
  assign w_rFire    = sb_arvalid && sb_arready;
  assign w_wFire    = sb_wvalid && sb_wready;

  assign sb_rvalid  = r_rvalid;
  assign sb_rdata   = r_rdata;
  assign sb_rresp   = r_rresp;
  assign sb_bvalid  = r_bvalid;
  assign sb_bresp   = r_bresp;

  // Expand the byte strobes into a bit mask for the write-first merge.
  always_comb begin
    w_wMask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_wMask[8*i +: 8] = {8{sb_wstrb[i]}};
    end
  end

  // Read data selection: old word, or the old word with the strobed bytes of
  // a same-cycle write to the same word patched in when write-first is chosen.
  always_comb begin
    w_rOld    = r_mem[w_rIdx];
    w_collide = w_rFire && w_wFire && w_rInRange && w_wInRange &&
                (w_rIdx == w_wIdx);
    w_rMerged = (w_rOld & ~w_wMask) | (sb_wdata & w_wMask);
    w_rNext   = w_rOld;
    if (!w_rInRange) begin
      w_rNext = '0;
    end else if ((COLL_MODE != 0) && w_collide) begin
      w_rNext = w_rMerged;
    end
  end

  // Memory array: byte-lane writes only, no reset so it maps onto block RAM.
  always_ff @(posedge sb_clk) begin
    if (w_wFire && w_wInRange) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (sb_wstrb[i]) begin
          r_mem[w_wIdx][8*i +: 8] <= sb_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read response slot: load on accept, hold while stalled, empty on drain.
  always_ff @(posedge sb_clk or posedge sb_rst) begin
    if (sb_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 1'b0;
    end else if (w_rFire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rNext;
      r_rresp  <= !w_rInRange;
    end else if (sb_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Write response slot: same load/hold/drain rules as the read side.
  always_ff @(posedge sb_clk or posedge sb_rst) begin
    if (sb_rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 1'b0;
    end else if (w_wFire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= !w_wInRange;
    end else if (sb_bready) begin
      r_bvalid <= 1'b0;
    end
  end

endmodule
